// File: rtl/mem_dma_if.sv
// Control and RAM-port bundle for mem_dma.
// slave = DMA engine side, master = the requester/RAM environment side.
interface mem_dma_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [ADDR_WIDTH:0]   len;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   words_left;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  start, mode, src_addr, dst_addr, len, fill_data, mem_q,
        output busy, done, words_left, mem_addr, mem_data, mem_we
    );

    modport master (
        output start, mode, src_addr, dst_addr, len, fill_data, mem_q,
        input  busy, done, words_left, mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/mem_dma.sv
// Block copy / fill engine driving one port of a synchronous-read dual-port RAM.
// Copy alternates RD/WR per word so mem_q is consumed the cycle after its address.
module mem_dma #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic     clk,
    input  logic     reset,
    mem_dma_if.slave bus
);
    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LW-1:0]         left_q, left_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            left_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            left_q  <= left_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        src_d          = src_q;
        dst_d          = dst_q;
        left_d         = left_q;
        fill_d         = fill_q;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = 1'b0;
        bus.words_left = left_q;
        bus.mem_addr   = '0;
        bus.mem_data   = '0;
        bus.mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    src_d  = bus.src_addr;
                    dst_d  = bus.dst_addr;
                    left_d = bus.len;
                    fill_d = bus.fill_data;
                    if (bus.len == '0)
                        state_d = S_DONE;
                    else if (bus.mode)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                bus.mem_addr = src_q;
                src_d        = src_q + 1'b1;
                state_d      = S_WR;
            end
            S_WR: begin
                bus.mem_addr = dst_q;
                bus.mem_we   = 1'b1;
                // Copy mode forwards the read data from the preceding RD cycle unregistered.
                bus.mem_data = mode_q ? fill_q : bus.mem_q;
                dst_d        = dst_q + 1'b1;
                left_d       = left_q - 1'b1;
                if (left_q == LW'(1))
                    state_d = S_DONE;
                else if (mode_q)
                    state_d = S_WR;
                else
                    state_d = S_RD;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: table of directed transfers, random transfers,
// and a mid-transfer reset, all checked against an array-level memory model.
`timescale 1ns/1ps
module tb_mem_dma;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM environment: synchronous read, write commits at the edge.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (bus.mem_we)
            ram[bus.mem_addr] <= bus.mem_data;
        else if (pre_we)
            ram[pre_addr] <= pre_data;
        ram_q <= ram[bus.mem_addr];
    end
    assign bus.mem_q = ram_q;

    // Reference memory image, updated by whole-transfer rules.
    logic [DW-1:0] ref_mem [DEPTH];
    int total = 0;
    int bad = 0;

    typedef struct {
        logic          m;
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        logic [AW:0]   n;
        logic [DW-1:0] f;
        int            exp_done;
        int            inj;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic model(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input int n, input logic [DW-1:0] f);
        for (int i = 0; i < n; i++) begin
            int wa, ra;
            wa = (int'(d) + i) % DEPTH;
            ra = (int'(s) + i) % DEPTH;
            ref_mem[wa] = m ? f : ref_mem[ra];
        end
    endtask

    task automatic chk_mem(input string name);
        int mism;
        int first;
        mism = 0;
        first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== ref_mem[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        if (mism != 0)
            $display("  first differing word at %0h: ram=%0h model=%0h", first, ram[first], ref_mem[first]);
        chk(name, mism, 0);
    endtask

    task automatic drive_start(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input logic [AW:0] n, input logic [DW-1:0] f);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.src_addr  = s;
        bus.dst_addr  = d;
        bus.len       = n;
        bus.fill_data = f;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.mode      = 1'($urandom);
        bus.src_addr  = AW'($urandom);
        bus.dst_addr  = AW'($urandom);
        bus.len       = (AW+1)'($urandom);
        bus.fill_data = DW'($urandom);
    endtask

    task automatic run_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW:0] n, input logic [DW-1:0] f,
                            input int exp_done, input int inj);
        int done_cyc, done_cnt, we_cnt, limit;
        logic busy_ok;
        logic [AW:0] wl_first;
        done_cyc = -1;
        done_cnt = 0;
        we_cnt   = 0;
        busy_ok  = 1'b1;
        wl_first = '0;
        limit    = 2 * int'(n) + 12;
        drive_start(m, s, d, n, f);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (c == 1) wl_first = bus.words_left;
            if (bus.mem_we) we_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if ((done_cyc < 0 || c <= done_cyc) && !bus.busy) busy_ok = 1'b0;
            if (done_cyc >= 0 && c > done_cyc && bus.busy) busy_ok = 1'b0;
            if (c == inj) begin
                bus.start     = 1'b1;
                bus.mode      = 1'b1;
                bus.dst_addr  = '0;
                bus.len       = 3;
                bus.fill_data = 16'hDEAD;
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        model(m, s, d, int'(n), f);
        chk("done_cycle", done_cyc, exp_done);
        chk("done_count", done_cnt, 1);
        chk("we_count", we_cnt, int'(n));
        chk("words_left_first", 32'(wl_first), 32'(n));
        chk("words_left_end", 32'(bus.words_left), 0);
        chk("busy_window", 32'(busy_ok), 1);
        chk_mem("mem_image");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] keep;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len = '0;
        bus.fill_data = '0;

        tbl[0] = '{m:1'b0, s:10'h010, d:10'h100, n:11'd4,    f:16'h0000, exp_done:9,    inj:0};
        tbl[1] = '{m:1'b1, s:10'h000, d:10'h3FE, n:11'd4,    f:16'hBEEF, exp_done:5,    inj:0};
        tbl[2] = '{m:1'b0, s:10'h123, d:10'h234, n:11'd0,    f:16'h5555, exp_done:1,    inj:0};
        tbl[3] = '{m:1'b0, s:10'h030, d:10'h0C0, n:11'd8,    f:16'h0000, exp_done:17,   inj:3};
        tbl[4] = '{m:1'b0, s:10'h020, d:10'h021, n:11'd2,    f:16'h0000, exp_done:5,    inj:0};
        tbl[5] = '{m:1'b1, s:10'h000, d:10'h155, n:11'd1024, f:16'h3C3C, exp_done:1025, inj:0};
        tbl[6] = '{m:1'b0, s:10'h3FD, d:10'h300, n:11'd5,    f:16'h0000, exp_done:11,   inj:0};
        tbl[7] = '{m:1'b1, s:10'h000, d:10'h077, n:11'd1,    f:16'h7E57, exp_done:2,    inj:0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_we", 32'(bus.mem_we), 0);
        chk("reset_addr", 32'(bus.mem_addr), 0);
        chk("reset_words_left", 32'(bus.words_left), 0);

        for (int i = 0; i < DEPTH; i++) poke(AW'(i), DW'($urandom));
        for (int i = 0; i < 4; i++) poke(AW'(16 + i), DW'(16'hA001 + i));
        poke(10'h020, 16'h1111);
        poke(10'h021, 16'h2222);

        for (int i = 0; i < 8; i++) begin
            keep = ram[2];
            run_xfer(tbl[i].m, tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].f, tbl[i].exp_done, tbl[i].inj);
            if (i == 0)
                for (int k = 0; k < 4; k++) chk("copy_dst", 32'(ram[256 + k]), 32'(16'hA001 + k));
            if (i == 1) begin
                chk("fill_wrap_0", 32'(ram[0]), 32'h0000BEEF);
                chk("fill_untouched", 32'(ram[2]), 32'(keep));
            end
            if (i == 4) begin
                chk("overlap_21", 32'(ram[33]), 32'h1111);
                chk("overlap_22", 32'(ram[34]), 32'h1111);
            end
        end

        for (int t = 0; t < 10; t++) begin
            logic m;
            int n;
            m = 1'($urandom);
            n = $urandom_range(0, 12);
            run_xfer(m, AW'($urandom), AW'($urandom), (AW+1)'(n), DW'($urandom),
                     (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1), 0);
        end

        for (int i = 0; i < 8; i++) poke(AW'(64 + i), DW'(16'hC000 + i));
        drive_start(1'b0, 10'h040, 10'h140, 11'd8, 16'h0000);
        for (int c = 1; c <= 5; c++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_done", 32'(bus.done), 0);
        chk("rst_mid_we", 32'(bus.mem_we), 0);
        chk("rst_mid_addr", 32'(bus.mem_addr), 0);
        chk("rst_mid_data", 32'(bus.mem_data), 0);
        chk("rst_mid_words_left", 32'(bus.words_left), 0);
        reset = 1'b1;
        model(1'b0, 10'h040, 10'h140, 2, 16'h0000);
        @(negedge clk);
        chk_mem("rst_mid_mem");
        run_xfer(1'b0, 10'h040, 10'h140, 11'd8, 16'h0000, 17, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_dma.md
# mem_dma

Block-transfer engine that drives one port of the on-chip dual-port RAM as the access initiator. It issues reads and writes in place of the CPU load/store path. On a `start` pulse it either copies `len` words from `src_addr` to `dst_addr` or fills `len` words at `dst_addr` with a constant. It accounts for the RAM's one-cycle synchronous read latency and reports completion with a single-cycle `done` pulse.

## Interface
- DATA_WIDTH, 16, word width; matches RAM data width
- ADDR_WIDTH, 10, word-address width; matches RAM address width

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; latched on accepted start
- src_addr  in  ADDR_WIDTH  first source word (copy only); latched on start
- dst_addr  in  ADDR_WIDTH  first destination word; latched on start
- len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; latched on start
- fill_data  in  DATA_WIDTH  fill value; latched on start
- busy  out  1  high from cycle after accepted start until DONE state exits
- done  out  1  one-cycle pulse at completion
- words_left  out  ADDR_WIDTH+1  remaining words to write
- mem_addr  out  ADDR_WIDTH  RAM port address
- mem_data  out  DATA_WIDTH  RAM port write data
- mem_we  out  1  RAM port write enable
- mem_q  in  DATA_WIDTH  RAM port read data; valid the cycle after its address is presented

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - start=1 latches mode, addresses, len and fill_data; words_left←len.
  - len=0 → DONE.
  - Otherwise mode=0 → RD; mode=1 → WR.
- RD (copy only): mem_addr=src pointer, mem_we=0; src pointer +1 → WR.
- WR:
  - mem_addr=dst pointer, mem_we=1.
  - mem_data=mem_q (combinational pass-through) in copy mode; latched fill value in fill mode.
  - dst pointer +1; words_left −1.
  - If words_left was 1 → DONE; else copy → RD, fill → WR.
- DONE: done=1 for exactly this cycle → IDLE.
- Pointers are ADDR_WIDTH bits and wrap modulo 2^ADDR_WIDTH (0x3FF+1 → 0x000). No error is flagged.
- Copy is strictly ascending, one read then one write per word. Overlapping ranges with dst > src replicate data. This is defined behaviour, not an error.
- start while not IDLE is ignored; latched parameters do not change mid-transfer.
- mem_we is high only in WR. In IDLE, RD and DONE, mem_we=0.
- Idle/DONE outputs: mem_addr=0, mem_data=0.
- Reset (reset=0 at a rising edge), from any state including mid-transfer:
  - state→IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_data=0, words_left=0, all pointers and latches 0.
  - A write in progress during that cycle still commits at that edge; no further accesses follow.

## Timing
- Edge E0 samples start=1 in IDLE. Cycle after E0 is the first transfer cycle; busy=1 from then.
- Copy, len=N≥1:
  - RD cycles at cycles 1,3,…,2N−1; WR cycles at cycles 2,4,…,2N; each write commits at the end of its cycle.
  - done=1 in cycle 2N+1, busy=1 in that cycle, IDLE in cycle 2N+2.
  - Next start is accepted at the edge ending cycle 2N+2.
- Fill, len=N≥1: WR cycles 1..N; done in cycle N+1.
- len=0: done in cycle 1; no memory access.
- Throughput: copy 2 cycles/word; fill 1 cycle/word.
- mem_q must be used only in the WR cycle that immediately follows the corresponding RD.

## Test plan
- Reset: hold reset=0 for 2 cycles, release -> busy=0, done=0, mem_we=0, mem_addr=0, words_left=0.
- Copy: RAM[0x010..0x013]=0xA001..0xA004; start mode=0, src=0x010, dst=0x100, len=4 -> RAM[0x100..0x103]=0xA001..0xA004; done pulses exactly in cycle 9; exactly 4 mem_we cycles.
- Fill with wrap: mode=1, dst=0x3FE, len=4, fill_data=0xBEEF -> RAM[0x3FE],[0x3FF],[0x000],[0x001]=0xBEEF; RAM[0x002] unchanged; done in cycle 5.
- Zero length and ignored start: len=0 -> done in cycle 1 and no mem_we. During a len=8 copy, pulse start with new params -> transfer completes unchanged; no second done.
- Overlap: RAM[0x20]=0x1111, RAM[0x21]=0x2222; copy src=0x20, dst=0x21, len=2 -> RAM[0x21]=0x1111, RAM[0x22]=0x1111.
- Reset mid-op: assert reset during cycle 5 of a len=8 copy -> next cycle IDLE with all outputs 0; only 2 words written; a new start afterwards runs correctly.
